// File: rtl/onfi_nand_master.sv
// onfi_nand_master: command-driven master for an 8-bit asynchronous NAND flash
// device (512+16 byte pages, 1 column + 3 row address cycles). Host opcodes
// either run NAND bus sequences or access internal registers/buffers.
module onfi_nand_master #(
    parameter int PAGE_SIZE = 528,
    parameter int ID_BYTES  = 8,
    parameter int T_WP      = 10,
    parameter int T_WH      = 6,
    parameter int T_RP      = 12,
    parameter int T_REH     = 6,
    parameter int T_WB      = 40
) (
    input  logic        clk,
    input  logic        nreset,
    output logic        nand_cle,
    output logic        nand_ale,
    output logic        nand_nwe,
    output logic        nand_nwp,
    output logic        nand_nce,
    output logic        nand_nre,
    input  logic        nand_rnb,
    inout  wire  [15:0] nand_data,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        busy,
    input  logic        activate,
    input  logic [5:0]  cmd_in,
    input  logic        enable
);

    localparam int CNT_W  = 16;
    localparam int PIDX_W = $clog2(PAGE_SIZE);
    localparam int IIDX_W = $clog2(ID_BYTES);

    localparam logic [5:0] M_RESET               = 6'h01;
    localparam logic [5:0] M_NAND_RESET          = 6'h04;
    localparam logic [5:0] M_NAND_READ_ID        = 6'h06;
    localparam logic [5:0] M_NAND_READ           = 6'h09;
    localparam logic [5:0] MI_GET_STATUS         = 6'h0D;
    localparam logic [5:0] MI_CHIP_ENABLE        = 6'h0E;
    localparam logic [5:0] MI_SET_ADDR           = 6'h10;
    localparam logic [5:0] MI_RESET_INDEX        = 6'h12;
    localparam logic [5:0] MI_GET_ID_BYTE        = 6'h13;
    localparam logic [5:0] MI_GET_DATA_PAGE_BYTE = 6'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FINISH,
        ST_WR_SETUP,
        ST_WR_LOW,
        ST_WR_HIGH,
        ST_WAIT_WB,
        ST_WAIT_RNB,
        ST_RD_LOW,
        ST_RD_HIGH
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_RESET,
        OP_READ_ID,
        OP_READ
    } op_t;

    typedef struct packed {
        logic       is_cmd;
        logic       is_last;
        logic [7:0] value;
    } wr_t;

    state_t             state, state_next;
    op_t                op, op_next, cmd_op;
    logic [2:0]         step, step_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [CNT_W-1:0]   rcnt, rcnt_next;
    logic [CNT_W-1:0]   read_len;
    logic               capture;
    logic               accept;
    wr_t                wr_cur, wr_next;
    logic               in_wr_next;
    logic               cle_next, ale_next, nwe_next, nre_next, oe_next;
    logic [7:0]         dq_next;
    logic               data_oe;
    logic [7:0]         data_q;
    logic               rnb_meta, rnb_sync;
    logic               chip_en;
    logic [31:0]        addr;
    logic [IIDX_W-1:0]  id_idx;
    logic [PIDX_W-1:0]  page_idx;
    logic [7:0]         id_buf [ID_BYTES];
    logic [7:0]         page_buf [PAGE_SIZE];

    // Byte, kind and last-flag of write number s of an operation.
    function automatic wr_t wr_entry(input op_t o, input logic [2:0] s, input logic [31:0] a);
        wr_t w;
        w = '0;
        case (o)
            OP_RESET: begin
                w.is_cmd  = 1'b1;
                w.is_last = 1'b1;
                w.value   = 8'hFF;
            end
            OP_READ_ID: begin
                w.is_cmd  = (s == 3'd0);
                w.is_last = (s != 3'd0);
                w.value   = (s == 3'd0) ? 8'h90 : 8'h00;
            end
            OP_READ: begin
                case (s)
                    3'd0:    begin w.is_cmd = 1'b1; w.value = 8'h00; end
                    3'd1:    w.value = a[7:0];
                    3'd2:    w.value = a[15:8];
                    3'd3:    w.value = a[23:16];
                    default: begin w.value = a[31:24]; w.is_last = 1'b1; end
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    assign busy      = (state != ST_IDLE);
    assign accept    = activate && !enable && !busy;
    assign nand_nwp  = 1'b0;
    assign nand_nce  = ~chip_en;
    assign read_len  = (op == OP_READ_ID) ? CNT_W'(ID_BYTES) : CNT_W'(PAGE_SIZE);
    assign wr_cur    = wr_entry(op, step, addr);

    assign nand_data[7:0]  = data_oe ? data_q : 8'hzz;
    assign nand_data[15:8] = 8'hzz;

    // Map a host opcode onto the flash operation it starts, if any.
    always_comb begin
        cmd_op = OP_NONE;
        case (cmd_in)
            M_NAND_RESET:   cmd_op = OP_RESET;
            M_NAND_READ_ID: cmd_op = OP_READ_ID;
            M_NAND_READ:    cmd_op = OP_READ;
            default:        cmd_op = OP_NONE;
        endcase
    end

    // Next-state, write step and phase/byte counters of the bus sequencer.
    always_comb begin
        state_next = state;
        op_next    = op;
        step_next  = step;
        cnt_next   = cnt;
        rcnt_next  = rcnt;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && (cmd_op != OP_NONE)) begin
                    op_next    = cmd_op;
                    step_next  = '0;
                    cnt_next   = '0;
                    rcnt_next  = '0;
                    state_next = chip_en ? ST_WR_SETUP : ST_FINISH;
                end
            end
            ST_FINISH: begin
                op_next    = OP_NONE;
                state_next = ST_IDLE;
            end
            ST_WR_SETUP: begin
                cnt_next   = '0;
                state_next = ST_WR_LOW;
            end
            ST_WR_LOW: begin
                if (cnt == CNT_W'(T_WP - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_WR_HIGH;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_WR_HIGH: begin
                if (cnt == CNT_W'(T_WH - 1)) begin
                    cnt_next = '0;
                    if (!wr_cur.is_last) begin
                        step_next  = step + 1'b1;
                        state_next = ST_WR_SETUP;
                    end else if (op == OP_READ_ID) begin
                        state_next = ST_RD_LOW;
                    end else begin
                        state_next = ST_WAIT_WB;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_WAIT_WB: begin
                if (cnt == CNT_W'(T_WB - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT_RNB;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_WAIT_RNB: begin
                if (rnb_sync) begin
                    cnt_next = '0;
                    if (op == OP_RESET) begin
                        op_next    = OP_NONE;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RD_LOW;
                    end
                end
            end
            ST_RD_LOW: begin
                if (cnt == CNT_W'(T_RP - 1)) begin
                    capture    = 1'b1;
                    cnt_next   = '0;
                    rcnt_next  = rcnt + 1'b1;
                    state_next = ST_RD_HIGH;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RD_HIGH: begin
                if (cnt == CNT_W'(T_REH - 1)) begin
                    cnt_next = '0;
                    if (rcnt == read_len) begin
                        op_next    = OP_NONE;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RD_LOW;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                op_next    = OP_NONE;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus strobe and data values for the upcoming state, registered below.
    always_comb begin
        wr_next    = wr_entry(op_next, step_next, addr);
        in_wr_next = (state_next == ST_WR_SETUP) || (state_next == ST_WR_LOW) ||
                     (state_next == ST_WR_HIGH);
        cle_next   = in_wr_next && wr_next.is_cmd;
        ale_next   = in_wr_next && !wr_next.is_cmd;
        nwe_next   = (state_next != ST_WR_LOW);
        nre_next   = (state_next != ST_RD_LOW);
        oe_next    = in_wr_next;
        dq_next    = in_wr_next ? wr_next.value : 8'h00;
    end

    // Sequencer state and glitch-free registered bus strobes.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= ST_IDLE;
            op       <= OP_NONE;
            step     <= '0;
            cnt      <= '0;
            rcnt     <= '0;
            nand_cle <= 1'b0;
            nand_ale <= 1'b0;
            nand_nwe <= 1'b1;
            nand_nre <= 1'b1;
            data_oe  <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state    <= state_next;
            op       <= op_next;
            step     <= step_next;
            cnt      <= cnt_next;
            rcnt     <= rcnt_next;
            nand_cle <= cle_next;
            nand_ale <= ale_next;
            nand_nwe <= nwe_next;
            nand_nre <= nre_next;
            data_oe  <= oe_next;
            data_q   <= dq_next;
        end
    end

    // Two-stage synchronizer for the asynchronous ready/busy line.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rnb_meta <= 1'b0;
            rnb_sync <= 1'b0;
        end else begin
            rnb_meta <= nand_rnb;
            rnb_sync <= rnb_meta;
        end
    end

    // Host register commands, buffer indices and the registered result byte.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            chip_en  <= 1'b0;
            addr     <= '0;
            id_idx   <= '0;
            page_idx <= '0;
            data_out <= 8'h00;
        end else if (accept) begin
            case (cmd_in)
                M_RESET: begin
                    chip_en  <= 1'b0;
                    addr     <= '0;
                    id_idx   <= '0;
                    page_idx <= '0;
                    data_out <= 8'h00;
                end
                MI_CHIP_ENABLE: chip_en <= 1'b1;
                MI_GET_STATUS:  data_out <= {5'b0, rnb_sync, chip_en, busy};
                MI_SET_ADDR:    addr <= {addr[23:0], data_in};
                MI_RESET_INDEX: page_idx <= '0;
                MI_GET_ID_BYTE: begin
                    data_out <= id_buf[id_idx];
                    id_idx   <= (id_idx == IIDX_W'(ID_BYTES - 1)) ? '0 : id_idx + 1'b1;
                end
                MI_GET_DATA_PAGE_BYTE: begin
                    data_out <= page_buf[page_idx];
                    page_idx <= (page_idx == PIDX_W'(PAGE_SIZE - 1)) ? '0 : page_idx + 1'b1;
                end
                M_NAND_READ_ID: id_idx <= '0;
                default: ;
            endcase
        end else if (capture && (op == OP_READ)) begin
            page_idx <= (page_idx == PIDX_W'(PAGE_SIZE - 1)) ? '0 : page_idx + 1'b1;
        end
    end

    // Store bytes sampled on the final low cycle of each read strobe.
    always_ff @(posedge clk) begin
        if (capture) begin
            if (op == OP_READ_ID) begin
                id_buf[IIDX_W'(rcnt)] <= nand_data[7:0];
            end else begin
                page_buf[page_idx] <= nand_data[7:0];
            end
        end
    end

endmodule

// File: tb/tb_onfi_nand_master.sv
// tb_onfi_nand_master: directed bench with a small NAND device model that logs
// write cycles, serves ID/page bytes on nRE and pulls RnB low after commands.
module tb_onfi_nand_master;

    localparam int PAGE_SIZE = 528;
    localparam int ID_BYTES  = 8;
    localparam int DEV_BUSY  = 150;

    logic        clk      = 1'b0;
    logic        nreset   = 1'b1;
    logic        activate = 1'b0;
    logic        enable   = 1'b0;
    logic [5:0]  cmd_in   = 6'h00;
    logic [7:0]  data_in  = 8'h00;
    logic        nand_rnb = 1'b1;
    logic        nand_cle, nand_ale, nand_nwe, nand_nwp, nand_nce, nand_nre;
    wire  [15:0] nand_data;
    logic [7:0]  data_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [9:0]  wr_log [$];
    int          rd_pulses    = 0;
    int          dev_idx      = 0;
    int          addr_cnt     = 0;
    int          dev_busy_cnt = 0;
    logic        dev_id_mode  = 1'b0;
    logic        nwe_prev     = 1'b1;
    logic        nre_prev     = 1'b1;
    logic [7:0]  dev_byte;

    onfi_nand_master dut (
        .clk       (clk),
        .nreset    (nreset),
        .nand_cle  (nand_cle),
        .nand_ale  (nand_ale),
        .nand_nwe  (nand_nwe),
        .nand_nwp  (nand_nwp),
        .nand_nce  (nand_nce),
        .nand_nre  (nand_nre),
        .nand_rnb  (nand_rnb),
        .nand_data (nand_data),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .activate  (activate),
        .cmd_in    (cmd_in),
        .enable    (enable)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] id_byte(input int i);
        case (i % 8)
            0:       return 8'hEC;
            1:       return 8'h76;
            2:       return 8'h5A;
            3:       return 8'h3F;
            4:       return 8'h00;
            5:       return 8'h11;
            6:       return 8'h22;
            default: return 8'h33;
        endcase
    endfunction

    function automatic logic [7:0] page_byte(input int i);
        logic [31:0] v;
        v = 32'(i * 37 + (i >> 4));
        return v[7:0];
    endfunction

    function automatic logic [9:0] logEntry(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 10'h3FF;
    endfunction

    // Device drives its current byte whenever the read strobe is low.
    always_comb dev_byte = dev_id_mode ? id_byte(dev_idx) : page_byte(dev_idx);
    assign nand_data[7:0] = nand_nre ? 8'hzz : dev_byte;

    // Device model: latches write cycles on nWE rise, steps data on nRE rise, drives RnB.
    always @(posedge clk) begin : device_model
        logic start_busy;
        start_busy = 1'b0;
        if (nreset && !nwe_prev && nand_nwe) begin
            wr_log.push_back({nand_cle, nand_ale, nand_data[7:0]});
            if (nand_cle) begin
                dev_idx  = 0;
                addr_cnt = 0;
                if (nand_data[7:0] == 8'h90) dev_id_mode = 1'b1;
                if (nand_data[7:0] == 8'h00) dev_id_mode = 1'b0;
                if (nand_data[7:0] == 8'hFF) start_busy = 1'b1;
            end else if (nand_ale) begin
                addr_cnt++;
                if (!dev_id_mode && addr_cnt == 4) start_busy = 1'b1;
            end
        end
        if (nreset && !nre_prev && nand_nre) begin
            rd_pulses++;
            dev_idx++;
        end
        nwe_prev = nand_nwe;
        nre_prev = nand_nre;
        if (start_busy) begin
            dev_busy_cnt = DEV_BUSY;
            nand_rnb <= 1'b0;
        end else if (dev_busy_cnt > 0) begin
            dev_busy_cnt--;
            if (dev_busy_cnt == 0) nand_rnb <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] cmd, input logic [7:0] din);
        @(negedge clk);
        cmd_in   = cmd;
        data_in  = din;
        activate = 1'b1;
        @(negedge clk);
        activate = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        int cyc;
        int base;
        int rd0;

        // Asynchronous reset pulse before the first clock edge.
        #2 nreset = 1'b0;
        #1;
        checkOutput("rst_nce",  32'(nand_nce), 32'h1);
        checkOutput("rst_nwe",  32'(nand_nwe), 32'h1);
        checkOutput("rst_nre",  32'(nand_nre), 32'h1);
        checkOutput("rst_cle",  32'(nand_cle), 32'h0);
        checkOutput("rst_ale",  32'(nand_ale), 32'h0);
        checkOutput("rst_nwp",  32'(nand_nwp), 32'h0);
        checkOutput("rst_busy", 32'(busy),     32'h0);
        checkOutput("rst_dout", 32'(data_out), 32'h0);
        #1 nreset = 1'b1;
        repeat (3) @(negedge clk);

        // Chip enable and status.
        applyStimulus(6'h0E, 8'h00);
        checkOutput("ce_nce", 32'(nand_nce), 32'h0);
        applyStimulus(6'h0D, 8'h00);
        checkOutput("status", 32'(data_out), 32'h06);

        // NAND reset: one command write of 0xFF, busy held through RnB low.
        base = wr_log.size();
        applyStimulus(6'h04, 8'h00);
        checkOutput("nrst_busy", 32'(busy), 32'h1);
        waitIdle("nrst_done", 2000, cyc);
        checkOutput("nrst_waited_rnb", 32'(cyc >= DEV_BUSY), 32'h1);
        checkOutput("nrst_nwrites", 32'(wr_log.size() - base), 32'd1);
        checkOutput("nrst_cmd", 32'(logEntry(base)), 32'h2FF);

        // READ_ID: 0x90 command, 0x00 address, eight read strobes.
        base = wr_log.size();
        rd0  = rd_pulses;
        applyStimulus(6'h06, 8'h00);
        waitIdle("rid_done", 1000, cyc);
        checkOutput("rid_nwrites", 32'(wr_log.size() - base), 32'd2);
        checkOutput("rid_cmd",  32'(logEntry(base)),     32'h290);
        checkOutput("rid_addr", 32'(logEntry(base + 1)), 32'h100);
        checkOutput("rid_nreads", 32'(rd_pulses - rd0), 32'(ID_BYTES));
        for (int i = 0; i < ID_BYTES + 1; i++) begin
            applyStimulus(6'h13, 8'h00);
            checkOutput($sformatf("id_byte%0d", i), 32'(data_out), 32'(id_byte(i)));
        end

        // Page read at address bytes 00,00,01,00.
        applyStimulus(6'h10, 8'h00);
        applyStimulus(6'h10, 8'h01);
        applyStimulus(6'h10, 8'h00);
        applyStimulus(6'h10, 8'h00);
        applyStimulus(6'h12, 8'h00);
        base = wr_log.size();
        rd0  = rd_pulses;
        applyStimulus(6'h09, 8'h00);
        checkOutput("rd_busy", 32'(busy), 32'h1);
        waitIdle("rd_done", 12000, cyc);
        checkOutput("rd_nwrites", 32'(wr_log.size() - base), 32'd5);
        checkOutput("rd_cmd",   32'(logEntry(base)),     32'h200);
        checkOutput("rd_addr0", 32'(logEntry(base + 1)), 32'h100);
        checkOutput("rd_addr1", 32'(logEntry(base + 2)), 32'h100);
        checkOutput("rd_addr2", 32'(logEntry(base + 3)), 32'h101);
        checkOutput("rd_addr3", 32'(logEntry(base + 4)), 32'h100);
        checkOutput("rd_nreads", 32'(rd_pulses - rd0), 32'(PAGE_SIZE));

        // Page retrieval, including the last byte and the wrap to byte 0.
        applyStimulus(6'h12, 8'h00);
        for (int i = 0; i < PAGE_SIZE + 1; i++) begin
            applyStimulus(6'h15, 8'h00);
            if (i < 4 || i >= PAGE_SIZE - 1)
                checkOutput($sformatf("page_byte%0d", i), 32'(data_out), 32'(page_byte(i % PAGE_SIZE)));
        end

        // Activate ignored while enable is high.
        enable = 1'b1;
        applyStimulus(6'h15, 8'h00);
        checkOutput("ign_enable", 32'(data_out), 32'(page_byte(0)));
        enable = 1'b0;
        applyStimulus(6'h15, 8'h00);
        checkOutput("after_enable", 32'(data_out), 32'(page_byte(1)));

        // Activate ignored while a flash operation is busy.
        base = wr_log.size();
        applyStimulus(6'h04, 8'h00);
        applyStimulus(6'h0D, 8'h00);
        checkOutput("ign_busy_dout", 32'(data_out), 32'(page_byte(1)));
        applyStimulus(6'h04, 8'h00);
        waitIdle("ign_busy_done", 2000, cyc);
        checkOutput("ign_busy_nwrites", 32'(wr_log.size() - base), 32'd1);
        applyStimulus(6'h15, 8'h00);
        checkOutput("ign_busy_idx", 32'(data_out), 32'(page_byte(2)));

        // Soft reset, then a flash command with the chip disabled.
        applyStimulus(6'h01, 8'h00);
        checkOutput("mrst_dout", 32'(data_out), 32'h0);
        checkOutput("mrst_nce",  32'(nand_nce), 32'h1);
        applyStimulus(6'h13, 8'h00);
        checkOutput("mrst_id_idx", 32'(data_out), 32'hEC);
        base = wr_log.size();
        applyStimulus(6'h04, 8'h00);
        checkOutput("dis_busy", 32'(busy), 32'h1);
        @(negedge clk);
        checkOutput("dis_done", 32'(busy), 32'h0);
        checkOutput("dis_nwrites", 32'(wr_log.size() - base), 32'd0);

        // Asynchronous abort in the middle of a write strobe.
        applyStimulus(6'h0E, 8'h00);
        applyStimulus(6'h06, 8'h00);
        cyc = 0;
        while (nand_nwe && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("abort_nwe_low", 32'(nand_nwe), 32'h0);
        #2 nreset = 1'b0;
        #1;
        checkOutput("abort_nwe",  32'(nand_nwe), 32'h1);
        checkOutput("abort_cle",  32'(nand_cle), 32'h0);
        checkOutput("abort_nce",  32'(nand_nce), 32'h1);
        checkOutput("abort_busy", 32'(busy),     32'h0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onfi_nand_master.md
Name: onfi_nand_master

Overview:
Command-driven master controller for an 8-bit asynchronous NAND flash device (K9F1208-class: 512+16-byte pages, 1 column plus 3 row address cycles). The host issues 6-bit opcodes with a one-cycle `activate` pulse. The block then does one of two things: it bit-bangs NAND bus cycles (CLE/ALE/nWE/nRE/nCE, RnB polling) for flash operations, or it answers internal register/buffer accesses. Read data is held in internal ID and page buffers for byte-wise retrieval by the host.

Parameters:
PAGE_SIZE, 528, page buffer depth in bytes
ID_BYTES, 8, ID buffer depth; bytes read by READ_ID
T_WP, 10, nWE low phase, clk cycles
T_WH, 6, nWE high phase, clk cycles
T_RP, 12, nRE low phase, clk cycles; data sampled on the last cycle
T_REH, 6, nRE high phase, clk cycles
T_WB, 40, cycles after the last command/address write before RnB is polled

Ports:
clk  in  1  system clock (rising edge)
nreset  in  1  asynchronous active-low reset
nand_cle  out  1  command latch enable
nand_ale  out  1  address latch enable
nand_nwe  out  1  write strobe, active low
nand_nwp  out  1  write protect, active low; constant 0 (read-only controller)
nand_nce  out  1  chip enable, active low
nand_nre  out  1  read strobe, active low
nand_rnb  in  1  ready/busy from device: 1 = ready, 0 = busy
nand_data  inout  16  bits [7:0] = device IO; bits [15:8] always Z
data_in  in  8  operand byte for host commands
data_out  out  8  result byte for host commands (registered)
busy  out  1  1 while a flash operation is in progress
activate  in  1  single-cycle command strobe
cmd_in  in  6  opcode
enable  in  1  active low; 0 = activate honoured, 1 = activate ignored

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (nreset).
- Reset values:
  - cle, ale = 0; nwe, nre, nce = 1; nwp = 0
  - nand_data = Z; data_out = 0x00; busy = 0
  - addr = 0; all indices = 0; chip_en = 0; state IDLE
- Command acceptance:
  - A command is accepted on a rising edge with activate=1, enable=0 and busy=0.
  - Otherwise activate is ignored; it is not queued.
- Internal commands (single cycle; busy stays 0; data_out valid on the edge after the accept edge):
  - 0x01 M_RESET: return to reset values.
  - 0x0E MI_CHIP_ENABLE: chip_en=1; nce=0 from the next cycle. Bits of data_in other than 0 are ignored.
  - 0x0D MI_GET_STATUS: data_out = {5'b0, rnb, chip_en, busy}.
  - 0x10 MI_SET_ADDR: addr = {addr[23:0], data_in}.
  - 0x12 MI_RESET_INDEX: page_idx = 0.
  - 0x13 MI_GET_ID_BYTE: data_out = id_buf[id_idx]; id_idx++ (wraps modulo ID_BYTES).
  - 0x15 MI_GET_DATA_PAGE_BYTE: data_out = page_buf[page_idx]; page_idx++ (wraps at PAGE_SIZE).
  - Any other opcode: no effect.
- Flash commands (busy=1 from the edge after accept until completion):
  - If chip_en=0, the command completes in one cycle with no bus activity.
  - 0x04 M_NAND_RESET: write cmd 0xFF; wait T_WB; wait rnb=1.
  - 0x06 M_NAND_READ_ID: write cmd 0x90; write addr 0x00; read ID_BYTES bytes into id_buf[0..]. id_idx=0 at completion.
  - 0x09 M_NAND_READ: write cmd 0x00; write addr bytes addr[7:0], addr[15:8], addr[23:16], addr[31:24]; wait T_WB; wait rnb=1; read PAGE_SIZE bytes into page_buf starting at page_idx (wrapping). page_idx is left advanced.
- Write bus cycle:
  - cle (command) or ale (address) is set and data[7:0] driven in the cycle before nwe falls.
  - nwe low for T_WP cycles, then high for T_WH cycles with data still driven.
  - cle/ale and data are then released (Z).
- Read bus cycle: nre low for T_RP cycles, data[7:0] captured on the final low cycle, then nre high for T_REH cycles.
- Completion: busy falls on the cycle the state returns to IDLE. nce remains = ~chip_en throughout.
- Reset mid-operation: immediate abort to reset values; strobes deasserted asynchronously.
- RnB wait: no timeout; busy stays high until rnb=1.

Test Plan:
- Reset: pulse nreset low for 2 ns -> nce=nwe=nre=1, cle=ale=0, busy=0, nand_data=Z.
- CHIP_ENABLE (0x0E, data_in=0), then NAND_RESET (0x04) -> nce=0; exactly one nwe low pulse with cle=1, data=0xFF; busy high until rnb returns 1, then 0.
- READ_ID (0x06) against a device model returning EC 76 5A 3F 00 … -> bus sequence 0x90 (cle), 0x00 (ale), then 8 nre pulses. Eight GET_ID_BYTE (0x13) pulses then yield EC,76,5A,3F,…; the ninth yields EC (wrap).
- GET_STATUS (0x0D) after chip enable, device idle -> data_out=0x06.
- SET_ADDR ×4 (0x00,0x01,0x00,0x00), RESET_INDEX, READ (0x09) -> address bytes 00,00,01,00 on the bus. Then RESET_INDEX followed by GET_DATA_PAGE_BYTE returns the model's page byte 0 and subsequent bytes in order.
- Activate while busy=1 or enable=1 -> ignored; state, indices and data_out unchanged.
